bus_dev_endpoint: RTL and testbench

Device-side endpoint that connects one device to the broadcast bus (`bs_gnrtr_n_rbtr`), one instance per bus driver slot. It buffers the device's outgoing packets in a TX queue: the bus reads this queue through `pndng`/`pop`/`D_pop`. It captures packets the bus delivers through `push`/`D_push` into an RX queue, after filtering on the destination ID. The block replaces the behavioural per-driver FIFO models with synthesizable RTL. The device host logic sits on its other side.

---
 rtl/bus_dev_pkg.sv | 9 +
 rtl/bus_dev_if.sv | 30 +++
 rtl/bus_dev_fifo.sv | 43 ++++
 rtl/bus_dev_endpoint.sv | 55 +++++
 tb/tb_bus_dev_endpoint.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_dev_pkg.sv
// bus_dev_pkg: shared ID width, broadcast ID and destination-field extraction
package bus_dev_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int MAX_PKT_W = 64;
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt, input int pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction
endpackage

// File: rtl/bus_dev_if.sv
// bus_dev_if: host-side and bus-side signals of one device endpoint
interface bus_dev_if #(parameter int pckg_sz = 16, parameter int depth = 8);
  localparam int CW = $clog2(depth) + 1;
  logic               host_push;
  logic [pckg_sz-1:0] host_din;
  logic               host_full;
  logic               host_pop;
  logic [pckg_sz-1:0] host_dout;
  logic               host_valid;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic [CW-1:0]      tx_count;
  logic [CW-1:0]      rx_count;
  logic [7:0]         rx_drop_cnt;
  logic [7:0]         rx_misroute_cnt;
  logic               err;
  modport slave (
    input  host_push, host_din, host_pop, pop, push, D_push,
    output host_full, host_dout, host_valid, pndng, D_pop,
           tx_count, rx_count, rx_drop_cnt, rx_misroute_cnt, err
  );
  modport master (
    output host_push, host_din, host_pop, pop, push, D_push,
    input  host_full, host_dout, host_valid, pndng, D_pop,
           tx_count, rx_count, rx_drop_cnt, rx_misroute_cnt, err
  );
endinterface

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: synchronous FWFT FIFO with wrap-bit pointers and ovf/udf pulses
module bus_dev_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       din,
  input  logic                   pop,
  output logic [width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count,
  output logic                   ovf,
  output logic                   udf
);
  localparam int AW = $clog2(depth);
  logic [width-1:0] r_mem [depth];
  logic [AW:0]      r_wr, r_rd;
  logic             w_wr, w_rd;
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty = r_wr == r_rd;
  assign count = r_wr - r_rd;
  // full/empty are pre-edge state, so a same-cycle pop never makes room for a push
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  assign ovf   = push && full;
  assign udf   = pop && empty;
  assign dout  = empty ? '0 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr[AW-1:0]] <= din;
        r_wr <= r_wr + 1'b1;
      end
      if (w_rd) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/bus_dev_endpoint.sv
// bus_dev_endpoint: device-side TX/RX queues with destination-ID filter for the broadcast bus
module bus_dev_endpoint
  import bus_dev_pkg::*;
#(
  parameter int              pckg_sz = 16,
  parameter int              depth   = 8,
  parameter logic [ID_W-1:0] id      = 8'h00,
  parameter logic [ID_W-1:0] bcast   = BCAST_ID
) (
  input logic      clk,
  input logic      reset,
  bus_dev_if.slave bus
);
  logic [ID_W-1:0] w_dest;
  logic            w_dest_ok, w_hit, w_misroute;
  logic            w_tx_empty, w_tx_ovf, w_tx_udf;
  logic            w_rx_empty, w_rx_ovf, w_rx_udf, w_unused_rx_full;
  logic [7:0]      r_drop, r_misroute;
  logic            r_err;
  assign w_dest     = dest_of(MAX_PKT_W'(bus.D_push), pckg_sz);
  assign w_dest_ok  = (w_dest == id) || (w_dest == bcast);
  assign w_hit      = bus.push && w_dest_ok;
  assign w_misroute = bus.push && !w_dest_ok;
  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk(clk), .reset(reset),
    .push(bus.host_push), .din(bus.host_din),
    .pop(bus.pop), .dout(bus.D_pop),
    .full(bus.host_full), .empty(w_tx_empty), .count(bus.tx_count),
    .ovf(w_tx_ovf), .udf(w_tx_udf)
  );
  bus_dev_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk(clk), .reset(reset),
    .push(w_hit), .din(bus.D_push),
    .pop(bus.host_pop), .dout(bus.host_dout),
    .full(w_unused_rx_full), .empty(w_rx_empty), .count(bus.rx_count),
    .ovf(w_rx_ovf), .udf(w_rx_udf)
  );
  assign bus.pndng           = !w_tx_empty;
  assign bus.host_valid      = !w_rx_empty;
  assign bus.rx_drop_cnt     = r_drop;
  assign bus.rx_misroute_cnt = r_misroute;
  assign bus.err             = r_err;
  // RX overflow is flow-control loss, counted but not a protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop     <= '0;
      r_misroute <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_rx_ovf && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_misroute && r_misroute != 8'hFF) r_misroute <= r_misroute + 8'd1;
      r_err <= r_err | w_tx_ovf | w_tx_udf | w_rx_udf;
    end
  end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// tb_bus_dev_endpoint: directed self-checking bench for bus_dev_endpoint (16-bit, depth 4, id 0x03)
module tb_bus_dev_endpoint;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  always #5 clk = ~clk;
  bus_dev_if #(.pckg_sz(16), .depth(4)) bif ();
  bus_dev_endpoint #(.pckg_sz(16), .depth(4), .id(8'h03)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bif.host_push = 1'b0;
    bif.host_din  = '0;
    bif.host_pop  = 1'b0;
    bif.pop       = 1'b0;
    bif.push      = 1'b0;
    bif.D_push    = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_full"},  32'(bif.host_full), 0);
    chk({tag, "_valid"}, 32'(bif.host_valid), 0);
    chk({tag, "_pndng"}, 32'(bif.pndng), 0);
    chk({tag, "_dpop"},  32'(bif.D_pop), 0);
    chk({tag, "_dout"},  32'(bif.host_dout), 0);
    chk({tag, "_txc"},   32'(bif.tx_count), 0);
    chk({tag, "_rxc"},   32'(bif.rx_count), 0);
    chk({tag, "_drop"},  32'(bif.rx_drop_cnt), 0);
    chk({tag, "_misr"},  32'(bif.rx_misroute_cnt), 0);
    chk({tag, "_err"},   32'(bif.err), 0);
  endtask
  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_reset("rst");
    // TX fill and drain
    for (int i = 0; i < 4; i++) begin
      bif.host_push = 1'b1;
      bif.host_din  = 16'(16'h0311 + i * 16'h11);
      step();
    end
    chk("tx_full4", 32'(bif.host_full), 1);
    chk("tx_cnt4", 32'(bif.tx_count), 4);
    chk("tx_err0", 32'(bif.err), 0);
    bif.host_din = 16'h0355;
    step();
    idle();
    chk("tx_ovf_err", 32'(bif.err), 1);
    chk("tx_ovf_cnt", 32'(bif.tx_count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("tx_drain", 32'(bif.D_pop), 32'h0311 + i * 32'h11);
      bif.pop = 1'b1;
      step();
    end
    idle();
    chk("tx_drain_pndng", 32'(bif.pndng), 0);
    chk("tx_drain_dpop", 32'(bif.D_pop), 0);
    // TX latency and concurrent push/pop
    do_reset();
    bif.host_push = 1'b1;
    bif.host_din  = 16'hAB01;
    step();
    idle();
    chk("lat_pndng", 32'(bif.pndng), 1);
    chk("lat_dpop", 32'(bif.D_pop), 32'hAB01);
    bif.pop       = 1'b1;
    bif.host_push = 1'b1;
    bif.host_din  = 16'hAB02;
    step();
    idle();
    chk("conc_cnt", 32'(bif.tx_count), 1);
    chk("conc_dpop", 32'(bif.D_pop), 32'hAB02);
    chk("conc_err", 32'(bif.err), 0);
    bif.pop = 1'b1;
    step();
    idle();
    chk("conc_empty", 32'(bif.pndng), 0);
    // RX filter
    bif.push = 1'b1;
    bif.D_push = 16'h03AA;
    step();
    bif.D_push = 16'hFFBB;
    step();
    bif.D_push = 16'h05CC;
    step();
    idle();
    chk("flt_cnt", 32'(bif.rx_count), 2);
    chk("flt_misr", 32'(bif.rx_misroute_cnt), 1);
    chk("flt_valid", 32'(bif.host_valid), 1);
    chk("flt_head0", 32'(bif.host_dout), 32'h03AA);
    bif.host_pop = 1'b1;
    step();
    chk("flt_head1", 32'(bif.host_dout), 32'hFFBB);
    step();
    idle();
    chk("flt_valid0", 32'(bif.host_valid), 0);
    chk("flt_dout0", 32'(bif.host_dout), 0);
    chk("flt_err0", 32'(bif.err), 0);
    // RX overflow and saturation
    for (int i = 0; i < 4; i++) begin
      bif.push   = 1'b1;
      bif.D_push = 16'(16'h0301 + i);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      bif.D_push   = 16'(16'h03E0 + i);
      bif.host_pop = (i == 5);
      step();
    end
    idle();
    chk("ovf_drop6", 32'(bif.rx_drop_cnt), 6);
    chk("ovf_cnt3", 32'(bif.rx_count), 3);
    chk("ovf_head", 32'(bif.host_dout), 32'h0302);
    bif.push   = 1'b1;
    bif.D_push = 16'h0305;
    step();
    for (int i = 0; i < 294; i++) begin
      bif.D_push = 16'hFF00;
      step();
    end
    idle();
    chk("sat_drop", 32'(bif.rx_drop_cnt), 255);
    chk("sat_cnt", 32'(bif.rx_count), 4);
    chk("sat_misr", 32'(bif.rx_misroute_cnt), 1);
    chk("sat_err", 32'(bif.err), 0);
    chk("sat_head", 32'(bif.host_dout), 32'h0302);
    // TX underflow, sticky err
    do_reset();
    bif.pop = 1'b1;
    step();
    idle();
    chk("udf_dpop", 32'(bif.D_pop), 0);
    chk("udf_pndng", 32'(bif.pndng), 0);
    chk("udf_err", 32'(bif.err), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("udf_sticky", 32'(bif.err), 1);
    end
    // reset mid-operation, then wrap-around
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bif.host_push = 1'b1;
      bif.host_din  = 16'(16'h0101 + i);
      bif.push      = 1'b1;
      bif.D_push    = 16'(16'h0310 + i);
      step();
    end
    idle();
    chk("mid_txc", 32'(bif.tx_count), 2);
    chk("mid_rxc", 32'(bif.rx_count), 2);
    reset         = 1'b1;
    bif.push      = 1'b1;
    bif.D_push    = 16'h0330;
    bif.pop       = 1'b1;
    bif.host_push = 1'b1;
    bif.host_din  = 16'h0199;
    bif.host_pop  = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk_reset("mid");
    for (int i = 0; i < 10; i++) begin
      bif.host_push = 1'b1;
      bif.host_din  = 16'(16'h5000 + i);
      bif.push      = 1'b1;
      bif.D_push    = 16'(16'h0340 + i);
      step();
      idle();
      chk("wrap_tx", 32'(bif.D_pop), 32'h5000 + i);
      chk("wrap_rx", 32'(bif.host_dout), 32'h0340 + i);
      bif.pop      = 1'b1;
      bif.host_pop = 1'b1;
      step();
      idle();
    end
    chk("wrap_txc", 32'(bif.tx_count), 0);
    chk("wrap_rxc", 32'(bif.rx_count), 0);
    chk("wrap_pndng", 32'(bif.pndng), 0);
    chk("wrap_err", 32'(bif.err), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
